// File: rtl/iic_cfg_pkg.sv
// Shared definitions for the I2C register-table configuration sequencer:
// state encoding, table entry field positions and the ms -> cycles helper.
package iic_cfg_pkg;

    localparam int TIMER_W  = 27;   // single shared timer width
    localparam int IDX_W    = 8;    // table index width
    localparam int LOAD_CYC = 3;    // hold time before each trigger

    // Table entry layout: {device_id, register address, data}
    localparam int DEV_MSB  = 31;
    localparam int DEV_LSB  = 24;
    localparam int ADDR_MSB = 23;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    typedef enum logic [3:0] {
        S_PWR_WAIT  = 4'd0,
        S_LOAD      = 4'd1,
        S_TRIG      = 4'd2,
        S_WAIT_L    = 4'd3,
        S_NEXT      = 4'd4,
        S_DONE      = 4'd5,
        S_ERR       = 4'd6,
        S_RD_LOAD   = 4'd7,
        S_RD_TRIG   = 4'd8,
        S_RD_WAIT_L = 4'd9
    } state_t;

    // Number of clock cycles in a delay given in milliseconds.
    function automatic longint unsigned ms_to_cycles(input longint unsigned ms,
                                                     input longint unsigned clk_fre);
        return (ms * clk_fre) / 64'd1000;
    endfunction

endpackage

// File: rtl/iic_cfg_rom.sv
// Constant register table for the HDMI transmitter bring-up.
// Each entry is {device_id[31:24], reg addr[23:8], data[7:0]}; indices at or
// beyond REG_NUM read as zero.
module iic_cfg_rom
    import iic_cfg_pkg::*;
#(
    parameter int REG_NUM = 16
) (
    input  logic [IDX_W-1:0] idx,
    output logic [31:0]      entry
);

    // Combinational table lookup by index.
    always_comb begin
        // NOTE: every variable written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
        entry = 32'h0;
        if (int'(idx) < REG_NUM) begin
            case (idx)
                8'd0:    entry = 32'h72_00_08_5B;
                8'd1:    entry = 32'h72_00_41_10;
                8'd2:    entry = 32'h7A_00_2F_C3;
                8'd3:    entry = 32'h72_00_1E_00;
                8'd4:    entry = 32'h72_00_1A_11;
                8'd5:    entry = 32'h72_00_25_00;
                8'd6:    entry = 32'h72_00_26_40;
                8'd7:    entry = 32'h72_00_09_00;
                8'd8:    entry = 32'h72_00_0A_10;
                8'd9:    entry = 32'h72_00_60_04;
                8'd10:   entry = 32'h72_00_3C_01;
                8'd11:   entry = 32'h72_00_1A_01;
                8'd12:   entry = 32'h7A_00_3D_0A;
                8'd13:   entry = 32'h7A_00_0F_C0;
                8'd14:   entry = 32'h72_00_BF_00;
                8'd15:   entry = 32'h72_00_1A_01;
                default: entry = 32'h0;
            endcase
        end
    end

endmodule

// File: rtl/iic_cfg_seq.sv
// Register-table configuration sequencer in front of the I2C byte driver.
// After reset and a power-up delay it issues one single-byte write per table
// entry through the driver's pluse/busy handshake, then reports done or error.
// Optional macro CFG_VERIFY_EN: read back each written byte, retry the write
// once on mismatch, and flag an error on a second mismatch.
module iic_cfg_seq
    import iic_cfg_pkg::*;
#(
    parameter int CLK_FRE       = 50_000_000,
    parameter int ADDR_BYTE     = 1,
    parameter int REG_NUM       = 16,
    parameter int INIT_DELAY_MS = 10,
    parameter int BUSY_H_TO     = 4096,
    parameter int BUSY_L_TO     = 2_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_start,
    output logic                   cfg_done,
    output logic                   cfg_err,
    output logic [7:0]             cfg_idx,
    output logic                   iic_pluse,
    output logic [7:0]             iic_device_id,
    output logic                   iic_w_r,
    output logic [3:0]             iic_byte_len,
    output logic [ADDR_BYTE*8-1:0] iic_addr,
    output logic [7:0]             iic_data_in,
    input  logic                   iic_busy,
    input  logic [7:0]             iic_data_out
);

    localparam int AW = ADDR_BYTE * 8;

    localparam longint unsigned PWR_CYC = ms_to_cycles(64'(INIT_DELAY_MS), 64'(CLK_FRE));

    // Terminal timer values: the timer counts 0..N-1 within one state.
    localparam logic [TIMER_W-1:0] PWR_LAST  = (PWR_CYC == 0) ? '0 : TIMER_W'(PWR_CYC - 1);
    localparam logic [TIMER_W-1:0] LOAD_LAST = TIMER_W'(LOAD_CYC - 1);
    localparam logic [TIMER_W-1:0] BH_LAST   = TIMER_W'(BUSY_H_TO - 1);
    localparam logic [TIMER_W-1:0] BL_LAST   = TIMER_W'(BUSY_L_TO - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(REG_NUM - 1);

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q;
    logic               timer_clr;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               start_q;
    logic               start_rise;
    logic               pend_q, pend_d;
    logic [31:0]        rom_entry;

`ifdef CFG_VERIFY_EN
    logic               retry_q, retry_d;
`endif

    iic_cfg_rom #(
        .REG_NUM (REG_NUM)
    ) u_rom (
        .idx   (idx_q),
        .entry (rom_entry)
    );

    // Address bits above the configured width are not driven to the bus.
    if (ADDR_BYTE == 1) begin : g_addr8
        logic unused_addr_hi;
        assign unused_addr_hi = ^rom_entry[ADDR_MSB:ADDR_LSB+8];
    end

`ifndef CFG_VERIFY_EN
    // Read data is only consumed by the read-back path.
    logic unused_rd;
    assign unused_rd = ^iic_data_out;
`endif

    assign start_rise   = cfg_start & ~start_q;
    assign cfg_idx      = idx_q;
    assign iic_byte_len = 4'd1;

    // Next-state logic: table walk, handshake timeouts and restart handling.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pend_d    = pend_q | start_rise;
        timer_clr = 1'b0;
`ifdef CFG_VERIFY_EN
        retry_d   = retry_q;
`endif
        case (state_q)
            S_PWR_WAIT: begin
                pend_d = 1'b0;
                if (start_rise) begin
                    idx_d     = '0;
                    timer_clr = 1'b1;
                end else if (timer_q == PWR_LAST) begin
                    state_d = S_LOAD;
                end
`ifdef CFG_VERIFY_EN
                retry_d = 1'b0;
`endif
            end
            S_LOAD: begin
                if (timer_q == LOAD_LAST) state_d = S_TRIG;
            end
            S_TRIG: begin
                if (iic_busy)                 state_d = S_WAIT_L;
                else if (timer_q == BH_LAST)  state_d = S_ERR;
            end
            S_WAIT_L: begin
                if (!iic_busy) begin
`ifdef CFG_VERIFY_EN
                    state_d = S_RD_LOAD;
`else
                    state_d = S_NEXT;
`endif
                end else if (timer_q == BL_LAST) begin
                    state_d = S_ERR;
                end
            end
            S_NEXT: begin
`ifdef CFG_VERIFY_EN
                retry_d = 1'b0;
`endif
                // A restart requested mid-access takes effect only here, so no
                // transfer is ever cut short.
                if (pend_q) begin
                    state_d = S_PWR_WAIT;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                end else if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_DONE, S_ERR: begin
                if (start_rise || pend_q) begin
                    state_d = S_PWR_WAIT;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                end
            end
`ifdef CFG_VERIFY_EN
            S_RD_LOAD: begin
                if (timer_q == LOAD_LAST) state_d = S_RD_TRIG;
            end
            S_RD_TRIG: begin
                if (iic_busy)                 state_d = S_RD_WAIT_L;
                else if (timer_q == BH_LAST)  state_d = S_ERR;
            end
            S_RD_WAIT_L: begin
                if (!iic_busy) begin
                    if (iic_data_out == iic_data_in) begin
                        state_d = S_NEXT;
                    end else if (!retry_q) begin
                        retry_d = 1'b1;
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_ERR;
                    end
                end else if (timer_q == BL_LAST) begin
                    state_d = S_ERR;
                end
            end
`endif
            default: state_d = S_PWR_WAIT;
        endcase
    end

    // State, timer, index and restart bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_PWR_WAIT;
            timer_q <= '0;
            idx_q   <= '0;
            start_q <= 1'b0;
            pend_q  <= 1'b0;
`ifdef CFG_VERIFY_EN
            retry_q <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q <= state_d;
            timer_q <= (timer_clr || (state_d != state_q)) ? '0 : timer_q + 1'b1;
            idx_q   <= idx_d;
            start_q <= cfg_start;
            pend_q  <= pend_d;
`ifdef CFG_VERIFY_EN
            retry_q <= retry_d;
`endif
        end
    end

    // Registered driver-side and status outputs; bus fields change only in LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iic_pluse     <= 1'b0;
            iic_w_r       <= 1'b1;
            iic_device_id <= '0;
            iic_addr      <= '0;
            iic_data_in   <= '0;
            cfg_done      <= 1'b0;
            cfg_err       <= 1'b0;
        end else begin
            iic_pluse <= (state_d == S_TRIG) || (state_d == S_RD_TRIG);
            cfg_done  <= (state_d == S_DONE);
            cfg_err   <= (state_d == S_ERR);
            if (state_q == S_LOAD && timer_q == '0) begin
                iic_device_id <= rom_entry[DEV_MSB:DEV_LSB];
                iic_addr      <= rom_entry[ADDR_LSB +: AW];
                iic_data_in   <= rom_entry[DATA_MSB:DATA_LSB];
                iic_w_r       <= 1'b1;
            end
            if (state_q == S_RD_LOAD) begin
                iic_w_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_iic_cfg_seq.sv
// Directed self-checking bench for iic_cfg_seq with a behavioural I2C driver
// model (busy 4 cycles after pluse, held 500 cycles) and a device register map.
// Build with CFG_VERIFY_EN defined to exercise the read-back path instead.
module tb_iic_cfg_seq;

    localparam int CLK_FRE       = 100_000;
    localparam int INIT_DELAY_MS = 1;
    localparam int PWR_CYC       = 100;          // 1 ms at 100 kHz
    localparam int REG_NUM       = 3;
    localparam int ADDR_BYTE     = 1;
    localparam int BUSY_H_TO     = 64;
    localparam int BUSY_L_TO     = 1000;
    localparam int BUSY_HOLD     = 500;
    localparam int LONG_HOLD     = 1500;

    localparam int W_DONE = 0, W_ERR = 1, W_PLUSE = 2, W_BUSY_LO = 3;

    typedef struct packed {
        logic [7:0] dev;
        logic [7:0] addr;
        logic [7:0] data;
        logic       w_r;
    } acc_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_start;
    logic       cfg_done, cfg_err;
    logic [7:0] cfg_idx;
    logic       iic_pluse;
    logic [7:0] iic_device_id;
    logic       iic_w_r;
    logic [3:0] iic_byte_len;
    logic [7:0] iic_addr;
    logic [7:0] iic_data_in;
    logic       iic_busy;
    logic [7:0] iic_data_out;

    int   passed = 0;
    int   total  = 0;
    int   done_rises = 0;
    acc_t log_q[$];

    bit         no_busy  = 1'b0;
    bit         long_en  = 1'b0;
    logic [7:0] long_addr = 8'h00;
    bit         bad_read = 1'b0;
    logic [7:0] dev_mem [256];

    iic_cfg_seq #(
        .CLK_FRE       (CLK_FRE),
        .ADDR_BYTE     (ADDR_BYTE),
        .REG_NUM       (REG_NUM),
        .INIT_DELAY_MS (INIT_DELAY_MS),
        .BUSY_H_TO     (BUSY_H_TO),
        .BUSY_L_TO     (BUSY_L_TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_start     (cfg_start),
        .cfg_done      (cfg_done),
        .cfg_err       (cfg_err),
        .cfg_idx       (cfg_idx),
        .iic_pluse     (iic_pluse),
        .iic_device_id (iic_device_id),
        .iic_w_r       (iic_w_r),
        .iic_byte_len  (iic_byte_len),
        .iic_addr      (iic_addr),
        .iic_data_in   (iic_data_in),
        .iic_busy      (iic_busy),
        .iic_data_out  (iic_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge cfg_done) done_rises++;

    // Expected write triple for each table entry (hand-copied from the table).
    function automatic acc_t exp_entry(input int i);
        case (i)
            0:       return '{dev: 8'h72, addr: 8'h08, data: 8'h5B, w_r: 1'b1};
            1:       return '{dev: 8'h72, addr: 8'h41, data: 8'h10, w_r: 1'b1};
            default: return '{dev: 8'h7A, addr: 8'h2F, data: 8'hC3, w_r: 1'b1};
        endcase
    endfunction

    // Behavioural driver + slave device: logs each access, stores writes,
    // answers reads from its register map (or 0x5A when corrupted).
    initial begin : driver_model
        acc_t acc;
        int   hold;
        iic_busy     = 1'b0;
        iic_data_out = 8'h00;
        forever begin
            @(posedge clk);
            if (rst_n === 1'b1 && iic_pluse === 1'b1 && !no_busy) begin
                acc = '{dev: iic_device_id, addr: iic_addr, data: iic_data_in, w_r: iic_w_r};
                log_q.push_back(acc);
                if (acc.w_r) dev_mem[acc.addr] = acc.data;
                hold = (long_en && acc.addr == long_addr) ? LONG_HOLD : BUSY_HOLD;
                for (int i = 0; i < 2 && rst_n; i++) @(posedge clk);
                #1;
                if (rst_n) iic_busy = 1'b1;
                for (int i = 0; i < hold && rst_n; i++) @(posedge clk);
                #1;
                if (!acc.w_r) iic_data_out = bad_read ? 8'h5A : dev_mem[acc.addr];
                iic_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_for(input int sel, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            case (sel)
                W_DONE:    ok = (cfg_done === 1'b1);
                W_ERR:     ok = (cfg_err === 1'b1);
                W_PLUSE:   ok = (iic_pluse === 1'b1);
                default:   ok = (iic_busy === 1'b0);
            endcase
            if (ok) break;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic test_reset();
        cfg_start = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (cfg_done !== 1'b0)      $display("FAIL reset_done: got %b want 0", cfg_done);          else passed++;
        total++; if (cfg_err !== 1'b0)       $display("FAIL reset_err: got %b want 0", cfg_err);            else passed++;
        total++; if (cfg_idx !== 8'd0)       $display("FAIL reset_idx: got %0d want 0", cfg_idx);           else passed++;
        total++; if (iic_pluse !== 1'b0)     $display("FAIL reset_pluse: got %b want 0", iic_pluse);        else passed++;
        total++; if (iic_w_r !== 1'b1)       $display("FAIL reset_w_r: got %b want 1", iic_w_r);            else passed++;
        total++; if (iic_byte_len !== 4'd1)  $display("FAIL reset_byte_len: got %0d want 1", iic_byte_len); else passed++;
        total++; if ({iic_device_id, iic_addr, iic_data_in} !== 24'h0)
            $display("FAIL reset_bus: got %h want 000000", {iic_device_id, iic_addr, iic_data_in});        else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_write_seq();
        bit ok;
        int base = log_q.size();
        wait_for(W_DONE, 3000, ok);
        total++; if (!ok) $display("FAIL seq_done_timeout: got done=%b want 1", cfg_done); else passed++;
        total++; if (log_q.size() - base !== 3)
            $display("FAIL seq_count: got %0d want 3", log_q.size() - base); else passed++;
        for (int i = 0; i < 3 && base + i < log_q.size(); i++) begin
            total++;
            if (log_q[base+i] !== exp_entry(i))
                $display("FAIL seq_entry%0d: got %h want %h", i, log_q[base+i], exp_entry(i));
            else passed++;
        end
        total++; if (cfg_idx !== 8'd2)  $display("FAIL seq_idx: got %0d want 2", cfg_idx);       else passed++;
        total++; if (iic_busy !== 1'b0) $display("FAIL seq_busy_at_done: got %b want 0", iic_busy); else passed++;
        total++; if (cfg_err !== 1'b0)  $display("FAIL seq_err: got %b want 0", cfg_err);         else passed++;
    endtask

    task automatic test_busy_h_timeout();
        bit ok;
        int n = 0;
        no_busy = 1'b1;
        pulse_start();
        wait_for(W_PLUSE, 400, ok);
        total++; if (!ok) $display("FAIL bh_pluse_timeout: got pluse=%b want 1", iic_pluse); else passed++;
        while (cfg_err !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++; if (n !== BUSY_H_TO) $display("FAIL bh_latency: got %0d want %0d", n, BUSY_H_TO); else passed++;
        total++; if (cfg_idx !== 8'd0)  $display("FAIL bh_idx: got %0d want 0", cfg_idx);        else passed++;
        total++; if (iic_pluse !== 1'b0) $display("FAIL bh_pluse: got %b want 0", iic_pluse);     else passed++;
        no_busy = 1'b0;
    endtask

    task automatic test_busy_l_timeout();
        bit ok;
        int base = log_q.size();
        long_en   = 1'b1;
        long_addr = 8'h41;
        pulse_start();
        wait_for(W_ERR, 3000, ok);
        total++; if (!ok) $display("FAIL bl_err_timeout: got err=%b want 1", cfg_err); else passed++;
        total++; if (cfg_idx !== 8'd1)   $display("FAIL bl_idx: got %0d want 1", cfg_idx);   else passed++;
        total++; if (cfg_done !== 1'b0)  $display("FAIL bl_done: got %b want 0", cfg_done);  else passed++;
        wait_for(W_BUSY_LO, 1000, ok);
        repeat (20) @(negedge clk);
        total++; if (log_q.size() - base !== 2)
            $display("FAIL bl_no_entry2: got %0d accesses want 2", log_q.size() - base); else passed++;
        total++; if (cfg_err !== 1'b1)   $display("FAIL bl_err_sticky: got %b want 1", cfg_err); else passed++;
        long_en = 1'b0;
    endtask

    task automatic test_start_mid_access();
        bit ok = 1'b0;
        int base = log_q.size();
        int d0   = done_rises;
        logic [7:0] exp_addr [5] = '{8'h08, 8'h41, 8'h08, 8'h41, 8'h2F};
        pulse_start();
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            ok = (log_q.size() - base >= 2) && (iic_busy === 1'b1);
        end
        total++; if (!ok) $display("FAIL sm_entry1_timeout: got %0d accesses want 2", log_q.size() - base); else passed++;
        pulse_start();
        wait_for(W_DONE, 4000, ok);
        total++; if (!ok) $display("FAIL sm_done_timeout: got done=%b want 1", cfg_done); else passed++;
        total++; if (log_q.size() - base !== 5)
            $display("FAIL sm_count: got %0d want 5", log_q.size() - base); else passed++;
        for (int i = 0; i < 5 && base + i < log_q.size(); i++) begin
            total++;
            if (log_q[base+i].addr !== exp_addr[i])
                $display("FAIL sm_order%0d: got %h want %h", i, log_q[base+i].addr, exp_addr[i]);
            else passed++;
        end
        total++; if (done_rises - d0 !== 1) $display("FAIL sm_done_once: got %0d want 1", done_rises - d0); else passed++;
        total++; if (cfg_idx !== 8'd2) $display("FAIL sm_idx: got %0d want 2", cfg_idx); else passed++;
    endtask

    task automatic test_reset_mid_access();
        bit ok = 1'b0;
        int n = 0;
        int base = log_q.size();
        pulse_start();
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            ok = (log_q.size() - base >= 1) && (iic_busy === 1'b1);
        end
        total++; if (!ok) $display("FAIL rm_busy_timeout: got busy=%b want 1", iic_busy); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if ({cfg_done, cfg_err, iic_pluse, iic_w_r} !== 4'b0001)
            $display("FAIL rm_async_flags: got %b want 0001", {cfg_done, cfg_err, iic_pluse, iic_w_r}); else passed++;
        total++; if ({cfg_idx, iic_device_id, iic_addr, iic_data_in} !== 32'h0)
            $display("FAIL rm_async_bus: got %h want 0", {cfg_idx, iic_device_id, iic_addr, iic_data_in}); else passed++;
        repeat (3) @(negedge clk);
        base = log_q.size();
        #2 rst_n = 1'b1;
        // Power-up wait, then 3 LOAD cycles, then the trigger.
        while (n < 400) begin
            @(posedge clk);
            n++;
            #1;
            if (iic_pluse === 1'b1) break;
        end
        total++; if (n !== PWR_CYC + 3) $display("FAIL rm_restart_latency: got %0d want %0d", n, PWR_CYC + 3); else passed++;
        repeat (3) @(negedge clk);
        total++;
        if (log_q.size() <= base || log_q[base] !== exp_entry(0))
            $display("FAIL rm_reissue_entry0: got %0d new accesses want entry0 %h", log_q.size() - base, exp_entry(0));
        else passed++;
        wait_for(W_DONE, 3000, ok);
        total++; if (!ok) $display("FAIL rm_done_timeout: got done=%b want 1", cfg_done); else passed++;
    endtask

    task automatic test_verify();
        bit ok;
        int base = log_q.size();
        wait_for(W_ERR, 5000, ok);
        total++; if (!ok) $display("FAIL vf_err_timeout: got err=%b want 1", cfg_err); else passed++;
        total++; if (log_q.size() - base !== 4)
            $display("FAIL vf_retry_count: got %0d want 4", log_q.size() - base); else passed++;
        for (int i = 0; i < 4 && base + i < log_q.size(); i++) begin
            total++;
            if ({log_q[base+i].addr, log_q[base+i].w_r} !== {8'h08, (i % 2 == 0)})
                $display("FAIL vf_retry_acc%0d: got %h/%b want 08/%b", i, log_q[base+i].addr, log_q[base+i].w_r, (i % 2 == 0));
            else passed++;
        end
        total++; if (cfg_idx !== 8'd0) $display("FAIL vf_err_idx: got %0d want 0", cfg_idx); else passed++;
        bad_read = 1'b0;
        base = log_q.size();
        pulse_start();
        wait_for(W_DONE, 6000, ok);
        total++; if (!ok) $display("FAIL vf_done_timeout: got done=%b want 1", cfg_done); else passed++;
        total++; if (log_q.size() - base !== 6)
            $display("FAIL vf_ok_count: got %0d want 6", log_q.size() - base); else passed++;
        total++; if (cfg_idx !== 8'd2) $display("FAIL vf_ok_idx: got %0d want 2", cfg_idx); else passed++;
        total++; if (cfg_err !== 1'b0) $display("FAIL vf_ok_err: got %b want 0", cfg_err); else passed++;
    endtask

    initial begin
`ifdef CFG_VERIFY_EN
        bad_read = 1'b1;
        test_reset();
        test_verify();
`else
        test_reset();
        test_write_seq();
        test_busy_h_timeout();
        test_busy_l_timeout();
        test_start_mid_access();
        test_reset_mid_access();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
